// File: rtl/gray_to_binary_dec.sv
// Gray-to-binary decoder with a valid/ready skid-free output register and a
// single-bit-step checker that keeps a saturating count of violations.
module gray_to_binary_dec #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] b,
  output logic             step_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [WIDTH-1:0] prev_g;
  logic             first;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] diff;
  logic             one_bit_step;
  logic             err_now;
  logic             accept;
  logic             acc;

  // Running XOR from the MSB down yields the binary value bit by bit.
  always_comb begin
    dec = '0;
    acc = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ g[i];
      dec[i] = acc;
    end
  end

  // Exactly one differing bit <=> diff is a nonzero power of two.
  always_comb begin
    diff         = g ^ prev_g;
    one_bit_step = (diff != '0) && ((diff & (diff - ONE_W)) == '0);
    err_now      = !first && !one_bit_step;
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      b         <= '0;
      step_err  <= 1'b0;
      err_cnt   <= '0;
      prev_g    <= '0;
      first     <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b1;
      b         <= dec;
      step_err  <= err_now;
      prev_g    <= g;
      first     <= 1'b0;
      if (err_now && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ONE_CNT;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_to_binary_dec.sv
// Scoreboard bench for gray_to_binary_dec: directed scenarios plus random
// traffic, checked against an arithmetic reference model.
module tb_gray_to_binary_dec;

  localparam int W  = 4;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  g;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  b;
  logic          step_err;
  logic [CW-1:0] err_cnt;

  gray_to_binary_dec #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .g(g), .out_valid(out_valid), .out_ready(out_ready), .b(b),
    .step_err(step_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  b;
    logic          e;
    logic [CW-1:0] c;
  } exp_t;

  exp_t         q[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] m_prev;
  bit           m_first;
  int           m_cnt;
  logic [W-1:0] last_g;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_prev  = '0;
    m_first = 1'b1;
    m_cnt   = 0;
  endfunction

  // Binary value = XOR of all right shifts of the Gray word.
  function automatic void model_accept(input logic [W-1:0] gv);
    exp_t         e;
    logic [W-1:0] bin;
    bit           err;
    bin = '0;
    for (int k = 0; k < W; k++) bin = bin ^ (gv >> k);
    err = m_first ? 1'b0 : ($countones(gv ^ m_prev) != 1);
    if (err && m_cnt < CNT_MAX) m_cnt++;
    e.b = bin;
    e.e = err;
    e.c = CW'(m_cnt);
    q.push_back(e);
    m_prev  = gv;
    m_first = 1'b0;
  endfunction

  // Monitor: pops and compares on every consumption, before the driver
  // registers a new acceptance in the same cycle.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n === 1'b1) begin
      check("out_valid_vs_model", 32'(out_valid), 32'(q.size() != 0));
      check("in_ready", 32'(in_ready), 32'((q.size() == 0) || out_ready));
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_output", 32'(1), 32'(0));
        end else begin
          e = q.pop_front();
          check("b", 32'(b), 32'(e.b));
          check("step_err", 32'(step_err), 32'(e.e));
          check("err_cnt", 32'(err_cnt), 32'(e.c));
        end
      end
    end
  end

  task automatic drive(input logic vld, input logic [W-1:0] gv, input logic ordy);
    @(negedge clk);
    in_valid  = vld;
    g         = gv;
    out_ready = ordy;
    #3;
    if (in_valid && in_ready) begin
      model_accept(gv);
      last_g = gv;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
  endtask

  // Reset asserted between clock edges; outputs must clear immediately.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #4;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check({tag, "_rst_out_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_rst_err_cnt"}, 32'(err_cnt), 32'(0));
    check({tag, "_rst_b"}, 32'(b), 32'(0));
    check({tag, "_rst_step_err"}, 32'(step_err), 32'(0));
    check({tag, "_rst_in_ready"}, 32'(in_ready), 32'(1));
    model_reset();
    @(negedge clk);
    #4;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] gv;
    in_valid  = 1'b0;
    g         = '0;
    out_ready = 1'b0;
    last_g    = '0;
    model_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("init_out_valid", 32'(out_valid), 32'(0));
    check("init_err_cnt", 32'(err_cnt), 32'(0));
    check("init_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    #4;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      gv = W'(i ^ (i >> 1));
      drive(1'b1, gv, 1'b1);
    end
    drain();
    check("sweep_err_cnt", 32'(err_cnt), 32'(0));

    do_reset("pt");
    drive(1'b1, 4'b0110, 1'b1);
    drive(1'b1, 4'b0010, 1'b1);
    drive(1'b1, 4'b0111, 1'b1);
    drain();
    check("bad_step_err_cnt", 32'(err_cnt), 32'(1));
    check("bad_step_b", 32'(b), 32'(4'b0101));

    do_reset("bp");
    drive(1'b1, 4'b0011, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0001, 1'b0);
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_b_stable", 32'(b), 32'(4'd2));
    end
    drive(1'b1, 4'b0001, 1'b1);
    @(posedge clk);
    #1;
    check("bp_valid_kept", 32'(out_valid), 32'(1));
    check("bp_new_b", 32'(b), 32'(4'd1));
    drain();

    do_reset("rw");
    drive(1'b1, 4'b1000, 1'b1);
    drive(1'b1, 4'b1000, 1'b1);
    drive(1'b1, 4'b0000, 1'b1);
    drain();

    do_reset("sat");
    drive(1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 4'b0000, 1'b1);
    drain();
    check("sat_err_cnt", 32'(err_cnt), 32'(CNT_MAX));

    do_reset("pre_mid");
    drive(1'b1, 4'b0011, 1'b0);
    drive(1'b0, 4'b0000, 1'b0);
    check("mid_pending_valid", 32'(out_valid), 32'(1));
    do_reset("mid");
    drive(1'b1, 4'b0101, 1'b1);
    @(posedge clk);
    #1;
    check("mid_after_b", 32'(b), 32'(4'b0110));
    check("mid_after_step_err", 32'(step_err), 32'(0));
    drain();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) < 7) gv = last_g ^ W'(1 << $urandom_range(W - 1));
      else gv = W'($urandom);
      drive(1'($urandom_range(3) != 0), gv, 1'($urandom_range(3) != 0));
    end
    drain();
    check("final_queue_empty", 32'(q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_to_binary_dec.md
GRAY_TO_BINARY_DEC -- requirements
Module: gray_to_binary_dec

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, meaning the code width in bits (legal range 2..16).
REQ-002 SHALL provide parameter CNT_W, default 8, meaning the error-counter width in bits.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL provide port in_valid, input, 1 bit: the g input holds a valid code word.
REQ-006 SHALL provide port in_ready, output, 1 bit: the block accepts g this cycle.
REQ-007 SHALL provide port g, input, WIDTH bits: the Gray-coded input word.
REQ-008 SHALL provide port out_valid, output, 1 bit: b and step_err are valid.
REQ-009 SHALL provide port out_ready, input, 1 bit: the downstream accepts b this cycle.
REQ-010 SHALL provide port b, output, WIDTH bits: the decoded binary word, registered.
REQ-011 SHALL provide port step_err, output, 1 bit: the word on b violated the single-bit-step rule.
REQ-012 SHALL provide port err_cnt, output, CNT_W bits: the saturating count of step violations.

Function
REQ-013 SHALL decode with b[WIDTH-1] = g[WIDTH-1] and b[i] = b[i+1] XOR g[i] for i = WIDTH-2 down to 0.
REQ-014 SHALL treat an input word as accepted on a rising edge where in_valid && in_ready.
REQ-015 SHALL treat an output word as consumed on a rising edge where out_valid && out_ready.
REQ-016 SHALL drive in_ready = !out_valid || out_ready, combinationally; there is no combinational path from in_valid to in_ready.
REQ-017 SHALL, on acceptance, load b, step_err and the previous-code register and set out_valid the next cycle (1-cycle latency).
REQ-018 SHALL, on consumption without a simultaneous acceptance, clear out_valid.
REQ-019 SHALL, on simultaneous consumption and acceptance, replace the output with the new word and keep out_valid at 1 (full throughput, 1 word/cycle).
REQ-020 SHALL, while out_valid=1 and out_ready=0, hold b, step_err and out_valid stable.
REQ-021 SHALL keep an internal prev_g register (WIDTH bits) and a first flag (set by reset).
REQ-022 SHALL compute step_err for an accepted word as: first=1 gives 0; otherwise, Hamming distance(g, prev_g) != 1 gives 1, and 0 otherwise. A repeat word (distance 0) counts as an error.
REQ-023 SHALL clear first on the first acceptance after reset.
REQ-024 SHALL increment err_cnt by 1 on each acceptance whose step_err evaluates to 1, saturating at 2^CNT_W-1 with no wrap.
REQ-025 SHALL treat wrap-around as a legal single step: 1000 -> 0000 for WIDTH=4.
REQ-026 SHALL ignore g while in_valid=0 or in_ready=0, leaving prev_g unchanged.

Reset
REQ-027 SHALL, while rst_n=0, immediately force out_valid=0, b=0, step_err=0, err_cnt=0, prev_g=0 and first=1, independent of clk.
REQ-028 SHALL drive in_ready=1 during reset, since out_valid=0.
REQ-029 SHALL discard any in-flight output word when reset is asserted mid-operation; the first accepted word after release has step_err=0.
REQ-030 SHALL take its first acceptance after reset release on the first rising edge where rst_n=1 and in_valid=1.

Verification
REQ-031 SHALL cover a sweep: with out_ready=1, feed g = i ^ (i>>1) for i = 0..15 -> b = i one cycle later, step_err=0 throughout, err_cnt=0.
REQ-032 SHALL cover a single point and a bad step: g=0110 -> b=0100; then 0010 followed by 0111 -> second output b=0101, step_err=1, err_cnt=1.
REQ-033 SHALL cover backpressure: hold out_ready=0 for 3 cycles after one acceptance -> in_ready=0, b stable; then release with in_valid=1 -> consume and accept in the same cycle, out_valid stays 1.
REQ-034 SHALL cover a repeat word and wrap: g=1000 then 1000 -> step_err=1; then 0000 -> step_err=0.
REQ-035 SHALL cover saturation: with CNT_W=2, 5 violations -> err_cnt=3.
REQ-036 SHALL cover mid-operation reset: assert rst_n=0 with out_valid=1 between clock edges -> out_valid=0 and err_cnt=0 immediately; after release, g=0101 -> b=0110, step_err=0.
